// File: rtl/sa_tile_engine.sv
// Single-clock NxN outer-product tile engine: buffered input beats are
// accumulated into an NxN tile over K beats, then drained row by row.
module sa_tile_engine #(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4,
    parameter int K_WIDTH   = 8,
    parameter int ACC_WIDTH = 2*DIN_WIDTH + K_WIDTH,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 8
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic [K_WIDTH-1:0]         cfg_k_minus_one,
    input  logic                       cfg_signed,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [2*N*DIN_WIDTH-1:0]   din,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [N*ACC_WIDTH-1:0]     dout,
    output logic                       dout_last,
    output logic                       busy
);

    localparam int BEAT_W = 2*N*DIN_WIDTH;
    localparam int ROW_W  = N*ACC_WIDTH;
    localparam int ENT_W  = ROW_W + 1;
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int RCNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ---------------- input FIFO (fall-through head) ----------------
    logic [BEAT_W-1:0] r_in_mem [IN_DEPTH];
    logic [IN_AW:0]    r_in_wptr;
    logic [IN_AW:0]    r_in_rptr;
    logic              w_in_empty;
    logic              w_in_full;
    logic              w_in_push;
    logic              w_in_pop;
    logic [BEAT_W-1:0] w_in_head;

    assign w_in_empty = (r_in_wptr == r_in_rptr);
    assign w_in_full  = (r_in_wptr[IN_AW] != r_in_rptr[IN_AW]) &&
                        (r_in_wptr[IN_AW-1:0] == r_in_rptr[IN_AW-1:0]);
    assign w_in_push  = din_valid && !w_in_full;
    assign w_in_head  = r_in_mem[r_in_rptr[IN_AW-1:0]];
    assign din_ready  = !w_in_full;

    always_ff @(posedge sys_clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr[IN_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_wptr <= '0;
            r_in_rptr <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wptr <= r_in_wptr + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + 1'b1;
            end
        end
    end

    // ---------------- output FIFO, entry = {last, row} ----------------
    logic [ENT_W-1:0]  r_out_mem [OUT_DEPTH];
    logic [OUT_AW:0]   r_out_wptr;
    logic [OUT_AW:0]   r_out_rptr;
    logic              w_out_empty;
    logic              w_out_full;
    logic              w_out_push;
    logic              w_out_pop;
    logic [ENT_W-1:0]  w_out_head;
    logic [ENT_W-1:0]  w_out_entry;

    assign w_out_empty = (r_out_wptr == r_out_rptr);
    assign w_out_full  = (r_out_wptr[OUT_AW] != r_out_rptr[OUT_AW]) &&
                         (r_out_wptr[OUT_AW-1:0] == r_out_rptr[OUT_AW-1:0]);
    assign w_out_pop   = !w_out_empty && dout_ready;
    assign w_out_head  = r_out_mem[r_out_rptr[OUT_AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wptr[OUT_AW-1:0]] <= w_out_entry;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_wptr <= '0;
            r_out_rptr <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wptr <= r_out_wptr + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + 1'b1;
            end
        end
    end

    // Masked while empty so the stale RAM contents never reach the sink.
    assign dout_valid = !w_out_empty;
    assign dout       = w_out_empty ? '0 : w_out_head[ROW_W-1:0];
    assign dout_last  = !w_out_empty && w_out_head[ROW_W];

    // ---------------- control FSM ----------------
    state_t               r_state;
    state_t               w_state_next;
    logic                 w_latch;
    logic [K_WIDTH-1:0]   r_kmax;
    logic [K_WIDTH-1:0]   r_kcnt;
    logic [RCNT_W-1:0]    r_rcnt;
    logic                 r_signed;
    logic                 w_k_last;
    logic                 w_r_last;

    assign w_k_last = (r_kcnt == r_kmax);
    assign w_r_last = (r_rcnt == RCNT_W'(N-1));
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_in_pop     = 1'b0;
        w_out_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_in_empty) begin
                    w_latch      = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!w_in_empty) begin
                    w_in_pop = 1'b1;
                    if (w_k_last) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_out_full) begin
                    w_out_push = 1'b1;
                    if (w_r_last) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kmax   <= '0;
            r_kcnt   <= '0;
            r_rcnt   <= '0;
            r_signed <= 1'b0;
        end else begin
            if (w_latch) begin
                r_kmax   <= cfg_k_minus_one;
                r_signed <= cfg_signed;
                r_kcnt   <= '0;
            end else if (w_in_pop) begin
                r_kcnt <= r_kcnt + 1'b1;
            end
            if (w_in_pop && w_k_last) begin
                r_rcnt <= '0;
            end else if (w_out_push) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    // ---------------- outer-product datapath ----------------
    // Operands are widened straight to ACC_WIDTH; the true product always fits,
    // so a truncated ACC_WIDTH multiply is exact for both signed and unsigned.
    logic [ACC_WIDTH-1:0] w_a_ext [N];
    logic [ACC_WIDTH-1:0] w_b_ext [N];
    logic [ACC_WIDTH-1:0] w_prod  [N][N];
    logic [ACC_WIDTH-1:0] r_acc   [N][N];
    logic [ROW_W-1:0]     w_drain_row;

    for (genvar gi = 0; gi < N; gi++) begin : g_ext
        logic [DIN_WIDTH-1:0] w_a;
        logic [DIN_WIDTH-1:0] w_b;
        assign w_a = w_in_head[gi*DIN_WIDTH +: DIN_WIDTH];
        assign w_b = w_in_head[(N+gi)*DIN_WIDTH +: DIN_WIDTH];
        assign w_a_ext[gi] = {{(ACC_WIDTH-DIN_WIDTH){r_signed & w_a[DIN_WIDTH-1]}}, w_a};
        assign w_b_ext[gi] = {{(ACC_WIDTH-DIN_WIDTH){r_signed & w_b[DIN_WIDTH-1]}}, w_b};
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign w_prod[gi][gj] = w_a_ext[gi] * w_b_ext[gj];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= '0;
                end
            end
        end else if (w_in_pop) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= (r_kcnt == '0) ? w_prod[i][j]
                                                  : r_acc[i][j] + w_prod[i][j];
                end
            end
        end
    end

    always_comb begin
        w_drain_row = '0;
        for (int j = 0; j < N; j++) begin
            w_drain_row[j*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_rcnt][j];
        end
    end

    assign w_out_entry = {w_r_last, w_drain_row};

endmodule

// File: tb/tb_sa_tile_engine.sv
// Self-checking bench for sa_tile_engine: directed tiles plus randomized jobs
// compared against a plain-arithmetic matrix model.
module tb_sa_tile_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int AW = 24;

    logic            sys_clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [KW-1:0]   cfg_k_minus_one = '0;
    logic            cfg_signed = 1'b0;
    logic            din_valid = 1'b0;
    logic            din_ready;
    logic [2*N*DW-1:0] din = '0;
    logic            dout_valid;
    logic            dout_ready = 1'b0;
    logic [N*AW-1:0] dout;
    logic            dout_last;
    logic            busy;

    int total = 0;
    int bad = 0;
    int beats_accepted = 0;
    int got_n = 0;

    logic [63:0] beat_buf [0:511];
    logic [95:0] exp_rows [0:3];
    logic [95:0] got_rows [0:127];
    logic        got_last [0:127];

    sa_tile_engine #(
        .DIN_WIDTH(DW), .N(N), .K_WIDTH(KW), .ACC_WIDTH(AW),
        .IN_DEPTH(16), .OUT_DEPTH(8)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .cfg_k_minus_one(cfg_k_minus_one), .cfg_signed(cfg_signed),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .dout_last(dout_last), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Reference: C[i][j] = sum over the job's beats of a[i]*b[j], kept to 24 bits.
    task automatic model_tile(input int base, input int k, input bit sgn);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    logic [7:0] ab;
                    logic [7:0] bb;
                    longint av;
                    longint bv;
                    ab = beat_buf[base+kk][i*8 +: 8];
                    bb = beat_buf[base+kk][(N+j)*8 +: 8];
                    av = sgn ? longint'(byte'(ab)) : longint'(ab);
                    bv = sgn ? longint'(byte'(bb)) : longint'(bb);
                    s += av * bv;
                end
                exp_rows[i][j*AW +: AW] = s[AW-1:0];
            end
        end
    endtask

    task automatic drive_beats(input int start, input int n);
        for (int idx = start; idx < start + n; idx++) begin
            int  wait_c;
            bit  took;
            while ($urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                tick();
            end
            din       = beat_buf[idx];
            din_valid = 1'b1;
            took      = 1'b0;
            wait_c    = 0;
            while (!took && wait_c < 600) begin
                took = din_ready;
                tick();
                wait_c++;
            end
            if (!took) begin
                total++;
                bad++;
                $display("FAIL beat_accept idx=%0d: no ready seen, required ready within 600 cycles", idx);
                din_valid = 1'b0;
                return;
            end
            beats_accepted++;
        end
        din_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit random_ready);
        int cyc;
        cyc   = 0;
        got_n = 0;
        while (got_n < n && cyc < 3000) begin
            bit          rdy;
            bit          v;
            logic [96:0] e;
            rdy = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            dout_ready = rdy;
            v = dout_valid;
            e = {dout_last, dout};
            tick();
            cyc++;
            if (v && rdy) begin
                got_rows[got_n] = e[95:0];
                got_last[got_n] = e[96];
                got_n++;
            end
        end
        dout_ready = 1'b0;
        total++;
        if (got_n != n) begin
            bad++;
            $display("FAIL row_count: got %0d rows, required %0d", got_n, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        din       = '1;
        din_valid = 1'b1;
        rst_n     = 1'b0;
        repeat (3) tick();
        total += 5;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_din_ready: got %b required 1", din_ready); end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid: got %b required 0", dout_valid); end
        if (dout !== '0) begin bad++; $display("FAIL rst_dout: got %h required 0", dout); end
        if (dout_last !== 1'b0) begin bad++; $display("FAIL rst_dout_last: got %b required 0", dout_last); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        din_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (10) tick();
        total += 2;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL idle_dout_valid: got %b required 0", dout_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b required 0", busy); end
        $display("test_reset done");
    endtask

    task automatic check_t2(input string tag);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                total++;
                if (got_rows[r][j*AW +: AW] !== 24'((r+1)*(j+5))) begin
                    bad++;
                    $display("FAIL %s C[%0d][%0d]: got %0d required %0d", tag, r, j,
                             got_rows[r][j*AW +: AW], (r+1)*(j+5));
                end
            end
            total++;
            if (got_last[r] !== (r == N-1)) begin
                bad++;
                $display("FAIL %s last[%0d]: got %b required %b", tag, r, got_last[r], (r == N-1));
            end
        end
    endtask

    task automatic test_k1_unsigned();
        int lat;
        cfg_k_minus_one = 8'd0;
        cfg_signed      = 1'b0;
        beat_buf[0]     = 64'h08070605_04030201;
        drive_beats(0, 1);
        lat = 0;
        while (!dout_valid && lat < 50) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL latency_k1: got %0d cycles required 3", lat); end
        collect(4, 1'b0);
        check_t2("k1");
        $display("test_k1_unsigned done latency=%0d", lat);
    endtask

    task automatic test_k2_signedness();
        for (int sgn = 0; sgn < 2; sgn++) begin
            logic [23:0] e;
            cfg_k_minus_one = 8'd1;
            cfg_signed      = sgn[0];
            beat_buf[0]     = 64'h02020202_FFFFFFFF;
            beat_buf[1]     = 64'h02020202_FFFFFFFF;
            e = (sgn != 0) ? 24'hFFFFFC : 24'h0003FC;
            fork
                drive_beats(0, 2);
                collect(4, 1'b1);
            join
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    total++;
                    if (got_rows[r][j*AW +: AW] !== e) begin
                        bad++;
                        $display("FAIL k2_sgn%0d C[%0d][%0d]: got %h required %h", sgn, r, j,
                                 got_rows[r][j*AW +: AW], e);
                    end
                end
            end
            $display("test_k2 signed=%0d done", sgn);
        end
    endtask

    task automatic test_k256();
        cfg_k_minus_one = 8'd255;
        cfg_signed      = 1'b0;
        for (int i = 0; i < 256; i++) beat_buf[i] = '1;
        fork
            drive_beats(0, 256);
            collect(4, 1'b1);
        join
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                total++;
                if (got_rows[r][j*AW +: AW] !== 24'hFE0100) begin
                    bad++;
                    $display("FAIL k256 C[%0d][%0d]: got %h required fe0100", r, j, got_rows[r][j*AW +: AW]);
                end
            end
        end
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL k256_busy: got %b required 0", busy); end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL k256_dout_valid: got %b required 0", dout_valid); end
        $display("test_k256 done");
    endtask

    task automatic test_backpressure();
        localparam int JOBS = 22;
        cfg_k_minus_one = 8'd0;
        cfg_signed      = 1'b0;
        for (int i = 0; i < JOBS; i++) beat_buf[i] = {$urandom, $urandom};
        beats_accepted = 0;
        dout_ready     = 1'b0;
        fork
            drive_beats(0, JOBS);
            begin
                repeat (80) tick();
                total += 4;
                if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_dout_valid: got %b required 1", dout_valid); end
                if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_din_ready: got %b required 0", din_ready); end
                if (beats_accepted !== 19) begin bad++; $display("FAIL bp_accepted: got %0d required 19", beats_accepted); end
                if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b required 1", busy); end
                collect(JOBS*4, 1'b1);
            end
        join
        for (int jb = 0; jb < JOBS; jb++) begin
            model_tile(jb, 1, 1'b0);
            for (int r = 0; r < N; r++) begin
                total += 2;
                if (got_rows[jb*4+r] !== exp_rows[r]) begin
                    bad++;
                    $display("FAIL bp_row job%0d r%0d: got %h required %h", jb, r, got_rows[jb*4+r], exp_rows[r]);
                end
                if (got_last[jb*4+r] !== (r == N-1)) begin
                    bad++;
                    $display("FAIL bp_last job%0d r%0d: got %b required %b", jb, r, got_last[jb*4+r], (r == N-1));
                end
            end
        end
        $display("test_backpressure done rows=%0d", got_n);
    endtask

    task automatic test_reset_mid_accum();
        int c;
        cfg_k_minus_one = 8'd7;
        cfg_signed      = 1'b0;
        for (int i = 0; i < 3; i++) beat_buf[i] = {$urandom, $urandom};
        drive_beats(0, 3);
        repeat (2) tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b required 1", busy); end
        do_reset();
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_dout_valid: got %b required 0", dout_valid); end
        cfg_k_minus_one = 8'd0;
        cfg_signed      = 1'b0;
        beat_buf[0]     = 64'h08070605_04030201;
        drive_beats(0, 1);
        c = 0;
        while (!busy && c < 20) begin tick(); c++; end
        cfg_k_minus_one = 8'd7;
        cfg_signed      = 1'b1;
        collect(4, 1'b0);
        check_t2("after_reset");
        $display("test_reset_mid_accum done");
    endtask

    task automatic test_random();
        for (int jb = 0; jb < 8; jb++) begin
            int k;
            bit sgn;
            k   = $urandom_range(1, 20);
            sgn = $urandom_range(0, 1);
            for (int i = 0; i < k; i++) beat_buf[i] = {$urandom, $urandom};
            cfg_k_minus_one = 8'(k - 1);
            cfg_signed      = sgn;
            fork
                begin
                    int c;
                    drive_beats(0, 1);
                    c = 0;
                    while (!busy && c < 20) begin tick(); c++; end
                    cfg_k_minus_one = 8'($urandom);
                    cfg_signed      = ~sgn;
                    drive_beats(1, k - 1);
                end
                collect(4, 1'b1);
            join
            model_tile(0, k, sgn);
            for (int r = 0; r < N; r++) begin
                total += 2;
                if (got_rows[r] !== exp_rows[r]) begin
                    bad++;
                    $display("FAIL rand job%0d r%0d: got %h required %h", jb, r, got_rows[r], exp_rows[r]);
                end
                if (got_last[r] !== (r == N-1)) begin
                    bad++;
                    $display("FAIL rand_last job%0d r%0d: got %b required %b", jb, r, got_last[r], (r == N-1));
                end
            end
            $display("test_random job%0d k=%0d signed=%0d done", jb, k, sgn);
        end
    endtask

    initial begin
        test_reset();
        test_k1_unsigned();
        test_k2_signedness();
        test_k256();
        test_backpressure();
        test_reset_mid_accum();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
